// File: rtl/coupling_axi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : coupling_axi_ctrl
// Brief    : AXI4-Lite slave for coupling-matrix weights; maps (s, d) to a
//            column K = (d - s - 1) mod N and drives the shared column bus.
// Revision : 1.0 - initial release
// ============================================================================
module coupling_axi_ctrl #(
    parameter int N       = 8,
    parameter int IDX_W   = 3,
    parameter int RD_WAIT = 2
) (
    input  logic              clk,
    input  logic              axi_rst,
    input  logic [31:0]       s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [31:0]       s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic              col_wready,
    output logic [N-1:0]      col_wr_match,
    output logic [15:0]       col_s_addr,
    output logic [15:0]       col_d_addr,
    output logic [31:0]       col_wdata,
    input  logic [32*N-1:0]   col_rdata
);
    localparam int             c_cnt_w   = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
    localparam logic [c_cnt_w-1:0] c_rd_init = c_cnt_w'(RD_WAIT - 1);
    localparam logic [IDX_W:0] c_n       = (IDX_W + 1)'(N);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_wr_strobe = 3'd1;
    localparam logic [2:0] c_st_wr_resp   = 3'd2;
    localparam logic [2:0] c_st_rd_settle = 3'd3;
    localparam logic [2:0] c_st_rd_resp   = 3'd4;

    logic [2:0]         r_state, w_next_state;
    logic [IDX_W-1:0]   r_s, r_d;
    logic [31:0]        r_wdata, r_rdata;
    logic               r_err;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_bresp, r_rresp;

    logic [IDX_W-1:0]   w_aw_s, w_aw_d, w_ar_s, w_ar_d, w_k;
    logic               w_aw_err, w_ar_err, w_wr_go, w_rd_go;
    logic [IDX_W:0]     w_diff, w_k_full;
    logic [N-1:0]       w_onehot;
    logic [31:0]        w_col_sel;
    logic               w_unused;

    assign w_aw_s   = s_awaddr[2 +: IDX_W];
    assign w_aw_d   = s_awaddr[2 + IDX_W +: IDX_W];
    assign w_ar_s   = s_araddr[2 +: IDX_W];
    assign w_ar_d   = s_araddr[2 + IDX_W +: IDX_W];
    assign w_aw_err = ({1'b0, w_aw_s} >= c_n) || ({1'b0, w_aw_d} >= c_n);
    assign w_ar_err = ({1'b0, w_ar_s} >= c_n) || ({1'b0, w_ar_d} >= c_n);

    // Readies are gated by reset so every output reads zero while it is held.
    assign w_wr_go  = !axi_rst && (r_state == c_st_idle) && s_awvalid && s_wvalid;
    assign w_rd_go  = !axi_rst && (r_state == c_st_idle) && s_arvalid
                      && !(s_awvalid && s_wvalid);
    assign s_awready = w_wr_go;
    assign s_wready  = w_wr_go;
    assign s_arready = w_rd_go;

    // A negative difference sets the extra MSB; adding N wraps it into range.
    assign w_diff   = {1'b0, r_d} - {1'b0, r_s} - {{IDX_W{1'b0}}, 1'b1};
    assign w_k_full = w_diff[IDX_W] ? (w_diff + c_n) : w_diff;
    assign w_k      = w_k_full[IDX_W-1:0];
    assign w_onehot = {{(N-1){1'b0}}, 1'b1} << w_k;

    always_comb begin
        w_col_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (w_k == IDX_W'(k)) begin
                w_col_sel = col_rdata[32*k +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_wr_go) begin
                    w_next_state = c_st_wr_strobe;
                end else if (w_rd_go) begin
                    w_next_state = c_st_rd_settle;
                end
            end
            c_st_wr_strobe: w_next_state = c_st_wr_resp;
            c_st_wr_resp:   if (s_bready) w_next_state = c_st_idle;
            c_st_rd_settle: if (r_cnt == '0) w_next_state = c_st_rd_resp;
            c_st_rd_resp:   if (s_rready) w_next_state = c_st_idle;
            default:        w_next_state = c_st_idle;
        endcase
    end

    always_comb begin
        s_bvalid     = 1'b0;
        s_rvalid     = 1'b0;
        col_wready   = 1'b0;
        col_wr_match = '0;
        case (r_state)
            c_st_wr_strobe: begin
                col_wready   = !r_err;
                col_wr_match = r_err ? '0 : w_onehot;
            end
            c_st_wr_resp:   s_bvalid = 1'b1;
            c_st_rd_settle: col_wr_match = r_err ? '0 : w_onehot;
            c_st_rd_resp:   s_rvalid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge axi_rst) begin
        if (axi_rst) begin
            r_s     <= '0;
            r_d     <= '0;
            r_wdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_bresp <= 2'b00;
            r_rresp <= 2'b00;
            r_rdata <= '0;
        end else begin
            if (w_wr_go) begin
                r_s     <= w_aw_s;
                r_d     <= w_aw_d;
                r_wdata <= s_wdata;
                r_err   <= w_aw_err;
                r_bresp <= w_aw_err ? 2'b10 : 2'b00;
            end else if (w_rd_go) begin
                r_s   <= w_ar_s;
                r_d   <= w_ar_d;
                r_err <= w_ar_err;
                r_cnt <= c_rd_init;
            end
            if (r_state == c_st_rd_settle) begin
                if (r_cnt == '0) begin
                    r_rdata <= r_err ? 32'd0 : w_col_sel;
                    r_rresp <= r_err ? 2'b10 : 2'b00;
                end else begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end
        end
    end

    assign s_bresp    = r_bresp;
    assign s_rresp    = r_rresp;
    assign s_rdata    = r_rdata;
    assign col_s_addr = 16'(r_s);
    assign col_d_addr = 16'(r_d);
    assign col_wdata  = r_wdata;

    assign w_unused = ^{s_awaddr[31:2+2*IDX_W], s_awaddr[1:0],
                        s_araddr[31:2+2*IDX_W], s_araddr[1:0], w_k_full[IDX_W]};

endmodule
`default_nettype wire

// File: tb/tb_coupling_axi_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_coupling_axi_ctrl
// Brief    : Scoreboard bench for coupling_axi_ctrl with an N=8 and an N=6
//            instance sharing one AXI driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coupling_axi_ctrl;
    typedef struct packed { int cyc; logic [7:0] match; logic [15:0] s; logic [15:0] d; logic [31:0] wdata; } col_t;
    typedef struct packed { int cyc; logic [7:0] match; } mt_t;
    typedef struct packed { int cyc; logic [1:0] resp; } b_t;
    typedef struct packed { int cyc; logic [31:0] data; logic [1:0] resp; } r_t;

    logic clk = 1'b0, axi_rst = 1'b1, sel = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b1, rready = 1'b1;

    logic aw8, w8, ar8, bv8, rv8, cw8, aw6, w6, ar6, bv6, rv6, cw6;
    logic [1:0] br8, rr8, br6, rr6;
    logic [31:0] rd8, cwd8, rd6, cwd6;
    logic [7:0] m8;
    logic [5:0] m6;
    logic [15:0] cs8, cd8, cs6, cd6;
    logic [255:0] crd8;
    logic [191:0] crd6;

    coupling_axi_ctrl #(.N(8), .IDX_W(3), .RD_WAIT(2)) dut8 (
        .clk(clk), .axi_rst(axi_rst),
        .s_awaddr(awaddr), .s_awvalid(awvalid & ~sel), .s_awready(aw8),
        .s_wdata(wdata), .s_wvalid(wvalid & ~sel), .s_wready(w8),
        .s_bresp(br8), .s_bvalid(bv8), .s_bready(bready),
        .s_araddr(araddr), .s_arvalid(arvalid & ~sel), .s_arready(ar8),
        .s_rdata(rd8), .s_rresp(rr8), .s_rvalid(rv8), .s_rready(rready),
        .col_wready(cw8), .col_wr_match(m8), .col_s_addr(cs8), .col_d_addr(cd8),
        .col_wdata(cwd8), .col_rdata(crd8));

    coupling_axi_ctrl #(.N(6), .IDX_W(3), .RD_WAIT(2)) dut6 (
        .clk(clk), .axi_rst(axi_rst),
        .s_awaddr(awaddr), .s_awvalid(awvalid & sel), .s_awready(aw6),
        .s_wdata(wdata), .s_wvalid(wvalid & sel), .s_wready(w6),
        .s_bresp(br6), .s_bvalid(bv6), .s_bready(bready),
        .s_araddr(araddr), .s_arvalid(arvalid & sel), .s_arready(ar6),
        .s_rdata(rd6), .s_rresp(rr6), .s_rvalid(rv6), .s_rready(rready),
        .col_wready(cw6), .col_wr_match(m6), .col_s_addr(cs6), .col_d_addr(cd6),
        .col_wdata(cwd6), .col_rdata(crd6));

    logic m_awready, m_wready, m_arready, m_bvalid, m_rvalid, m_colw;
    logic [1:0] m_bresp, m_rresp;
    logic [31:0] m_rdata, m_cwd;
    logic [7:0] m_match;
    logic [15:0] m_s, m_d;
    assign m_awready = sel ? aw6 : aw8;
    assign m_wready  = sel ? w6 : w8;
    assign m_arready = sel ? ar6 : ar8;
    assign m_bvalid  = sel ? bv6 : bv8;
    assign m_rvalid  = sel ? rv6 : rv8;
    assign m_colw    = sel ? cw6 : cw8;
    assign m_bresp   = sel ? br6 : br8;
    assign m_rresp   = sel ? rr6 : rr8;
    assign m_rdata   = sel ? rd6 : rd8;
    assign m_cwd     = sel ? cwd6 : cwd8;
    assign m_match   = sel ? {2'b00, m6} : m8;
    assign m_s       = sel ? cs6 : cs8;
    assign m_d       = sel ? cd6 : cd8;

    int checks = 0, errors = 0, cyc = 0;
    col_t colq[$];
    mt_t  mq[$];
    b_t   bq[$];
    r_t   rq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name, input logic [127:0] act);
        checks++;
        errors++;
        $display("FAIL %s: actual event %h with nothing expected (cycle %0d)", name, act, cyc);
    endtask

    function automatic logic [31:0] addr(input int s, input int d);
        return 32'((d << 5) | (s << 2));
    endfunction

    // Handshake-level sampling at the active edge, used by the hold checks.
    logic hs_b = 1'b0, hs_r = 1'b0, pb = 1'b0, pr = 1'b0;
    always @(posedge clk) begin
        hs_b = m_bvalid && bready;
        hs_r = m_rvalid && rready;
    end

    always @(negedge clk) begin
        col_t ce; mt_t me; b_t be; r_t re;
        if (axi_rst) begin
            pb = 1'b0;
            pr = 1'b0;
        end else begin
            if (m_colw) begin
                if (colq.size() == 0) unexpected("col_strobe", {cyc, m_match, m_s, m_d, m_cwd});
                else begin
                    ce = colq.pop_front();
                    chk("col_strobe", {cyc, m_match, m_s, m_d, m_cwd}, ce);
                end
            end else if (m_match != 8'd0) begin
                if (mq.size() == 0) unexpected("rd_match", {cyc, m_match});
                else begin
                    me = mq.pop_front();
                    chk("rd_match", {cyc, m_match}, me);
                end
            end
            if (m_bvalid && !pb) begin
                if (bq.size() == 0) unexpected("bresp", {cyc, m_bresp});
                else begin
                    be = bq.pop_front();
                    chk("bresp", {cyc, m_bresp}, be);
                end
            end
            if (m_rvalid && !pr) begin
                if (rq.size() == 0) unexpected("rresp", {cyc, m_rdata, m_rresp});
                else begin
                    re = rq.pop_front();
                    chk("rresp", {cyc, m_rdata, m_rresp}, re);
                end
            end
            if (pb && !hs_b) chk("bvalid_held", m_bvalid, 1'b1);
            if (pr && !hs_r) chk("rvalid_held", m_rvalid, 1'b1);
            pb = m_bvalid;
            pr = m_rvalid;
        end
    end

    task automatic do_write(input int s, input int d, input logic [31:0] dat,
                            input bit err, input logic [7:0] match);
        bit done = 1'b0;
        col_t ce; b_t be;
        @(negedge clk);
        awaddr = addr(s, d); wdata = dat; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (m_awready && m_wready) begin
                done = 1'b1;
                ce = '{cyc + 1, match, 16'(s), 16'(d), dat};
                if (!err) colq.push_back(ce);
                be = '{cyc + 2, err ? 2'b10 : 2'b00};
                bq.push_back(be);
            end
            @(posedge clk);
            #1;
            if (!done) @(negedge clk);
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!done) unexpected("write_accept_timeout", 128'(addr(s, d)));
    endtask

    task automatic do_read(input int s, input int d, input logic [31:0] dat, input logic [1:0] resp,
                           input logic [7:0] match, input int nm, input bit want_r);
        bit done = 1'b0;
        mt_t me; r_t re;
        @(negedge clk);
        araddr = addr(s, d); arvalid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            if (m_arready) begin
                done = 1'b1;
                for (int j = 1; j <= nm; j++) begin
                    me = '{cyc + j, match};
                    mq.push_back(me);
                end
                re = '{cyc + 3, dat, resp};
                if (want_r) rq.push_back(re);
            end
            @(posedge clk);
            #1;
            if (!done) @(negedge clk);
        end
        arvalid = 1'b0;
        if (!done) unexpected("read_accept_timeout", 128'(addr(s, d)));
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (colq.size() == 0 && mq.size() == 0 && bq.size() == 0 && rq.size() == 0 && !m_bvalid && !m_rvalid) break;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 8; k++) crd8[32*k +: 32] = (k == 4) ? 32'h1234_5678 : 32'hAAAA_AAAA;
        for (int k = 0; k < 6; k++) crd6[32*k +: 32] = 32'h5555_AAAA;

        repeat (3) @(negedge clk);
        chk("reset_outputs_n8", {aw8, w8, ar8, bv8, rv8, cw8, br8, rr8, rd8, cwd8, m8, cs8, cd8}, '0);
        chk("reset_outputs_n6", {aw6, w6, ar6, bv6, rv6, cw6, br6, rr6, rd6, cwd6, m6, cs6, cd6}, '0);
        #1 axi_rst = 1'b0;

        do_write(2, 5, 32'hCAFE_0001, 1'b0, 8'b0000_0100);
        do_write(6, 1, 32'h1111_2222, 1'b0, 8'b0000_0100);
        do_write(3, 3, 32'h3333_4444, 1'b0, 8'b1000_0000);
        do_read(0, 5, 32'h1234_5678, 2'b00, 8'b0001_0000, 2, 1'b1);
        drain();

        // Write pair and read arrive together; B is stalled five cycles.
        bready = 1'b0;
        awaddr = addr(4, 4); wdata = 32'h5555_0007; araddr = addr(1, 2);
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        #1;
        chk("concurrent_ready", {m_awready, m_wready, m_arready}, 3'b110);
        begin
            col_t ce; b_t be;
            ce = '{cyc + 1, 8'h80, 16'd4, 16'd4, 32'h5555_0007};
            colq.push_back(ce);
            be = '{cyc + 2, 2'b00};
            bq.push_back(be);
        end
        @(posedge clk);
        #1 awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        for (int i = 0; i < 40 && n < 5; i++) begin
            @(negedge clk);
            #1;
            chk("arready_blocked", m_arready, 1'b0);
            if (m_bvalid) n++;
        end
        chk("bvalid_hold_cycles", n, 5);
        bready = 1'b1;
        do_read(1, 2, 32'hAAAA_AAAA, 2'b00, 8'b0000_0001, 2, 1'b1);
        drain();

        // Reset lands in the read settle window; the read must vanish.
        do_read(2, 7, 32'h0, 2'b00, 8'b0001_0000, 1, 1'b0);
        @(negedge clk);
        #2 axi_rst = 1'b1;
        #1;
        chk("reset_midread", {aw8, w8, ar8, bv8, rv8, cw8, br8, rr8, rd8, cwd8, m8, cs8, cd8}, '0);
        repeat (2) @(negedge clk);
        #1 axi_rst = 1'b0;
        repeat (6) @(negedge clk);
        do_read(0, 5, 32'h1234_5678, 2'b00, 8'b0001_0000, 2, 1'b1);
        drain();

        sel = 1'b1;
        do_write(7, 0, 32'hDEAD_BEEF, 1'b1, 8'h00);
        do_read(0, 6, 32'h0, 2'b10, 8'h00, 0, 1'b1);
        do_write(0, 0, 32'h0000_0600, 1'b0, 8'b0010_0000);
        do_write(4, 1, 32'h0000_0641, 1'b0, 8'b0000_0100);
        drain();

        chk("col_queue_empty", colq.size(), 0);
        chk("match_queue_empty", mq.size(), 0);
        chk("b_queue_empty", bq.size(), 0);
        chk("r_queue_empty", rq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/coupling_axi_ctrl.md
Name: coupling_axi_ctrl

Overview:
AXI4-Lite slave that owns all host access to the DIMPLE coupling matrix weight storage. It decodes a byte address into a (source spin, destination spin) pair and derives the target column K from that pair. It drives the shared column write bus (strobe, per-column match, s/d address, data) and selects and registers the addressed column's rdata. It sits directly upstream of the N coupled_col instances.

Parameters:
N, 8, number of spins and number of coupling columns.
IDX_W, 3, address bits per spin index; requires 2^IDX_W >= N.
RD_WAIT, 2, settle cycles between column select and rdata capture; minimum 1.

Ports:
clk  in  1  system clock.
axi_rst  in  1  asynchronous, active-high reset.
s_awaddr  in  32  write address.
s_awvalid  in  1  write address valid.
s_awready  out  1  write address ready.
s_wdata  in  32  write data; strobes ignored, full-word writes only.
s_wvalid  in  1  write data valid.
s_wready  out  1  write data ready.
s_bresp  out  2  write response.
s_bvalid  out  1  write response valid.
s_bready  in  1  write response ready.
s_araddr  in  32  read address.
s_arvalid  in  1  read address valid.
s_arready  out  1  read address ready.
s_rdata  out  32  read data.
s_rresp  out  2  read response.
s_rvalid  out  1  read valid.
s_rready  in  1  read ready.
col_wready  out  1  one-cycle weight write strobe to all columns.
col_wr_match  out  N  one-hot column select; bit K goes to column K's wr_match.
col_s_addr  out  16  source spin index, zero-extended.
col_d_addr  out  16  destination spin index, zero-extended.
col_wdata  out  32  write data to columns.
col_rdata  in  32*N  concatenated column rdata; column K occupies bits [32K+31:32K].

Behaviour:
- Address decode: s = addr[2+:IDX_W]; d = addr[2+IDX_W+:IDX_W]. Other address bits are ignored.
- Column index: K = (d - s - 1) mod N, computed in IDX_W+1 bits with a conditional add of N. s == d gives K = N-1, the self-coupling column, and is valid.
- Decode error: s >= N or d >= N. A write error produces no strobe, no match, and bresp=2'b10. A read error returns rdata=0 and rresp=2'b10.
- Responses are always 2'b00 when there is no decode error.
- FSM states: IDLE, WR_STROBE, WR_RESP, RD_SETTLE, RD_RESP.
- IDLE, write: s_awready and s_wready are asserted combinationally only when s_awvalid and s_wvalid are both high. Both handshakes complete in the same cycle. Address and data are latched, then go to WR_STROBE.
- IDLE, read: s_arready is asserted when s_arvalid is high and no write pair is present. The address is latched, the wait counter is loaded with RD_WAIT-1, then go to RD_SETTLE.
- Priority: a write pair beats a pending read in the same cycle. The read is accepted on a later IDLE cycle.
- WR_STROBE (1 cycle):
  - col_wready=1 and col_wr_match bit K=1, unless there is a decode error.
  - col_s_addr, col_d_addr and col_wdata are valid this cycle.
  - Go to WR_RESP.
- WR_RESP: s_bvalid=1 and held until s_bready, then go to IDLE.
- RD_SETTLE: col_wr_match bit K is held and col_wready=0. When the counter reaches 0, capture the col_rdata slice for K into the s_rdata register and go to RD_RESP.
- RD_RESP: s_rvalid=1 and held until s_rready, then go to IDLE.
- Only one transaction is outstanding at a time. No new AW, W or AR handshake is accepted outside IDLE.
- Latency, measured from handshake cycle t:
  - write: strobe at t+1, bvalid at t+2;
  - read: rvalid at t+RD_WAIT+1.
- col_wr_match is all zero in IDLE, WR_RESP and RD_RESP. col_s_addr, col_d_addr and col_wdata hold their last latched values.
- Reset (asynchronous, any state):
  - state returns to IDLE;
  - every output goes to 0 (all readies, valids, resp, rdata, col_*);
  - any in-flight transaction is dropped with no response.

Test Plan:
- N=8, write addr s=2, d=5, data 0xCAFE0001 -> one-cycle col_wready at t+1, col_wr_match=8'b00000100, col_s_addr=2, col_d_addr=5, col_wdata=0xCAFE0001; bvalid at t+2 with bresp=00.
- Wrap and diagonal: s=6, d=1 -> col_wr_match=8'b00000100 (K=2); s=d=3 -> col_wr_match=8'b10000000 (K=7).
- Read, RD_WAIT=2, s=0, d=5, column 4 rdata=0x12345678, other columns 0xAAAAAAAA -> col_wr_match=8'b00010000 for 2 cycles, then rvalid at t+3 with rdata=0x12345678 and rresp=00.
- N=6, IDX_W=3, write with s=7 -> col_wready never asserted, col_wr_match=0, bresp=10; read with d=6 -> rdata=0, rresp=10.
- AW, W and AR all valid in the same cycle, with bready held low 5 cycles -> write accepted first; bvalid held 5 cycles; arready stays 0 until after the B handshake; read completes afterwards.
- axi_rst asserted during RD_SETTLE -> all outputs 0 immediately; no rvalid after release; next read behaves normally.
